// File: rtl/ahb_lite_burst_addr_gen.sv
// AHB-Lite master address-phase engine: one burst command at a time onto HTRANS/HADDR/control,
// with HREADY stalls, WRAP wrapping, 1KB splitting of undefined INCR, BUSY insertion and ERROR cancel.
package ahb_types_pkg;
  typedef enum logic [1:0] {TR_IDLE = 2'd0, TR_BUSY = 2'd1, TR_NONSEQ = 2'd2, TR_SEQ = 2'd3} ahb_trans_e;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD, SZ_4W, SZ_8W, SZ_16W, SZ_32W} ahb_size_e;
  typedef enum logic [2:0] {BU_SINGLE, BU_INCR, BU_WRAP4, BU_INCR4,
                            BU_WRAP8, BU_INCR8, BU_WRAP16, BU_INCR16} ahb_burst_e;
endpackage

module ahb_lite_burst_addr_gen
  import ahb_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_write,
  input  logic              insert_busy,
  output logic              cmd_err,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HWRITE,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              burst_done,
  output logic              burst_err
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;
  localparam int         MAX_SIZE = $clog2(DATA_W / 8);

  function automatic logic [4:0] fixed_beats(input logic [2:0] b);
    case (ahb_burst_e'(b))
      BU_WRAP4,  BU_INCR4:  return 5'd4;
      BU_WRAP8,  BU_INCR8:  return 5'd8;
      BU_WRAP16, BU_INCR16: return 5'd16;
      default:              return 5'd1;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] last_idx(input logic [2:0] b, input logic [LEN_W-1:0] len);
    if (b == BU_INCR) return len;
    return LEN_W'(fixed_beats(b) - 5'd1);
  endfunction

  logic [0:0]        state_q, state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        hsize_q, hsize_d, hburst_q, hburst_d;
  logic              hwrite_q, hwrite_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              dvld_q, dvld_d, dlast_q, dlast_d, cerr_q, cerr_d;

  logic              on_beat, last_on_bus, cancel, accept, legal, is_wrap, fixed_incr;
  logic [ADDR_W-1:0] inc, bmask, nxt;
  logic [12:0]       end_off;

  assign on_beat     = (htrans_q == TR_NONSEQ) || (htrans_q == TR_SEQ);
  assign last_on_bus = on_beat && (left_q == '0);
  assign cancel      = dvld_q && HRESP && !HREADY;
  // Either ERROR cycle blocks new commands so the cancel fully drains first.
  assign cmd_ready   = !(dvld_q && HRESP) && ((state_q == S_IDLE) || (last_on_bus && HREADY));
  assign accept      = cmd_valid && cmd_ready;

  assign is_wrap = (hburst_q == BU_WRAP4) || (hburst_q == BU_WRAP8) || (hburst_q == BU_WRAP16);
  assign inc     = ADDR_W'(1) << hsize_q;
  assign bmask   = (ADDR_W'(fixed_beats(hburst_q)) << hsize_q) - ADDR_W'(1);
  assign nxt     = is_wrap ? ((haddr_q & ~bmask) | ((haddr_q + inc) & bmask)) : (haddr_q + inc);

  assign fixed_incr = (cmd_burst == BU_INCR4) || (cmd_burst == BU_INCR8) || (cmd_burst == BU_INCR16);
  assign end_off    = 13'(cmd_addr[9:0]) + (13'(fixed_beats(cmd_burst)) << cmd_size);
  assign legal      = (int'(cmd_size) <= MAX_SIZE)
                   && ((cmd_addr & ((ADDR_W'(1) << cmd_size) - ADDR_W'(1))) == '0)
                   && !(fixed_incr && (end_off > 13'd1024));

  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hburst_d = hburst_q;
    hwrite_d = hwrite_q;
    left_d   = left_q;
    dvld_d   = dvld_q;
    dlast_d  = dlast_q;
    cerr_d   = 1'b0;
    if (HREADY) begin
      dvld_d  = on_beat;
      dlast_d = last_on_bus;
    end
    if (cancel) begin
      state_d  = S_IDLE;
      htrans_d = TR_IDLE;
      left_d   = '0;
    end else if (state_q == S_ACTIVE && HREADY) begin
      if (last_on_bus) begin
        state_d  = S_IDLE;
        htrans_d = TR_IDLE;
      end else if (on_beat) begin
        haddr_d = nxt;
        left_d  = left_q - 1'b1;
        // Undefined INCR restarts as a fresh NONSEQ at every 1KB line.
        if (hburst_q == BU_INCR && nxt[9:0] == '0) htrans_d = TR_NONSEQ;
        else                                       htrans_d = insert_busy ? TR_BUSY : TR_SEQ;
      end else begin
        htrans_d = insert_busy ? TR_BUSY : TR_SEQ;
      end
    end
    if (accept) begin
      if (legal) begin
        state_d  = S_ACTIVE;
        htrans_d = TR_NONSEQ;
        haddr_d  = cmd_addr;
        hsize_d  = cmd_size;
        hburst_d = cmd_burst;
        hwrite_d = cmd_write;
        left_d   = last_idx(cmd_burst, cmd_len);
      end else begin
        cerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      htrans_q <= TR_IDLE;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hburst_q <= BU_SINGLE;
      hwrite_q <= 1'b0;
      left_q   <= '0;
      dvld_q   <= 1'b0;
      dlast_q  <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hburst_q <= hburst_d;
      hwrite_q <= hwrite_d;
      left_q   <= left_d;
      dvld_q   <= dvld_d;
      dlast_q  <= dlast_d;
      cerr_q   <= cerr_d;
    end
  end

  assign HTRANS     = htrans_q;
  assign HADDR      = haddr_q;
  assign HSIZE      = hsize_q;
  assign HBURST     = hburst_q;
  assign HWRITE     = hwrite_q;
  assign cmd_err    = cerr_q;
  // Done on the last data phase, or on the closing cycle of a two-cycle ERROR.
  assign burst_done = dvld_q && HREADY && (dlast_q || HRESP);
  assign burst_err  = burst_done && HRESP;
endmodule

// File: tb/tb_ahb_lite_burst_addr_gen.sv
// Bench for ahb_lite_burst_addr_gen: randomized bus behaviour, accepted beats scoreboarded against
// an arithmetic burst model, plus directed reset, split, wrap, error, reject and back-to-back cases.
module tb_ahb_lite_burst_addr_gen;
  import ahb_types_pkg::*;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, insert_busy = 1'b0, HREADY = 1'b1, HRESP = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0, cmd_burst = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_ready, cmd_err, HWRITE, burst_done, burst_err;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE, HBURST;

  always #5 HCLK = ~HCLK;

  ahb_lite_burst_addr_gen #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .cmd_write(cmd_write), .insert_busy(insert_busy), .cmd_err(cmd_err), .HTRANS(HTRANS),
    .HADDR(HADDR), .HSIZE(HSIZE), .HBURST(HBURST), .HWRITE(HWRITE), .HREADY(HREADY),
    .HRESP(HRESP), .burst_done(burst_done), .burst_err(burst_err));

  int nvec = 0, nmis = 0;

  logic [31:0] exp_addr[$];
  logic [1:0]  exp_trans[$];
  bit          exp_legal;

  logic [31:0] ob_addr[$];
  logic [1:0]  ob_trans[$];
  int          bz_idx[$];
  logic [31:0] bz_addr[$];
  int done_cnt, derr_cnt, cerr_cnt, hold_bad, ctl_bad, done_cyc, last_cyc, post_err_tr, timed_out;

  // Reference: beat list from the burst rules with plain integer arithmetic.
  task automatic model(input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu, input logic [7:0] ln);
    longint nb, inc, bnd, base, cur, la;
    exp_addr.delete(); exp_trans.delete();
    la  = longint'(a);
    inc = longint'(1) << sz;
    case (bu)
      3'd0:       nb = 1;
      3'd1:       nb = longint'(ln) + 1;
      3'd2, 3'd3: nb = 4;
      3'd4, 3'd5: nb = 8;
      default:    nb = 16;
    endcase
    exp_legal = (sz <= 3'd2) && (la % inc == 0) &&
                !((bu == 3'd3 || bu == 3'd5 || bu == 3'd7) && ((la % 1024) + nb * inc > 1024));
    if (!exp_legal) return;
    bnd = nb * inc; base = la - (la % bnd); cur = la;
    for (longint i = 0; i < nb; i++) begin
      exp_addr.push_back(32'(cur));
      exp_trans.push_back((i == 0 || (bu == 3'd1 && cur % 1024 == 0)) ? TR_NONSEQ : TR_SEQ);
      if (bu == 3'd2 || bu == 3'd4 || bu == 3'd6) cur = base + ((cur - base + inc) % bnd);
      else                                        cur = (cur + inc) % 64'h1_0000_0000;
    end
  endtask

  // Issues one command and plays the slave side, recording what the bus showed.
  task automatic run_cmd(input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu, input logic [7:0] ln,
                         input bit wr, input int rdy_pct, input int busy_pct, input int err_beat);
    int dp_beat, errph;
    logic [1:0] p_tr; logic [31:0] p_ad; bit p_stall;
    ob_addr.delete(); ob_trans.delete(); bz_idx.delete(); bz_addr.delete();
    done_cnt = 0; derr_cnt = 0; cerr_cnt = 0; hold_bad = 0; ctl_bad = 0;
    done_cyc = -1; last_cyc = -1; post_err_tr = -1; timed_out = 1;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_addr = a; cmd_size = sz; cmd_burst = bu; cmd_len = ln; cmd_write = wr;
    HREADY = 1'b1; HRESP = 1'b0; insert_busy = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    dp_beat = -1; errph = 0; p_stall = 1'b0; p_tr = '0; p_ad = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge HCLK);
      if (dp_beat >= 0 && dp_beat == err_beat && errph == 0) begin HREADY = 1'b0; HRESP = 1'b1; errph = 1; end
      else if (errph == 1) begin HREADY = 1'b1; HRESP = 1'b1; errph = 2; end
      else begin HREADY = ($urandom_range(99) < rdy_pct); HRESP = 1'b0; end
      insert_busy = ($urandom_range(99) < busy_pct);
      #1;
      if (p_stall && (HTRANS !== p_tr || HADDR !== p_ad)) hold_bad++;
      if (errph == 2 && post_err_tr < 0) post_err_tr = int'(HTRANS);
      if (HTRANS != TR_IDLE && (HSIZE !== sz || HBURST !== bu || HWRITE !== wr)) ctl_bad++;
      if (cmd_err) cerr_cnt++;
      if (burst_done) begin done_cnt++; done_cyc = cyc; if (burst_err) derr_cnt++; end
      if (HTRANS == TR_BUSY) begin bz_idx.push_back(ob_addr.size()); bz_addr.push_back(HADDR); end
      if (HREADY) begin
        if (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ) begin
          ob_addr.push_back(HADDR); ob_trans.push_back(HTRANS);
          dp_beat = ob_addr.size() - 1; last_cyc = cyc;
        end else dp_beat = -1;
      end
      p_stall = !HREADY && !HRESP; p_tr = HTRANS; p_ad = HADDR;
      if ((done_cnt > 0 || cerr_cnt > 0) && HTRANS == TR_IDLE) begin timed_out = 0; break; end
    end
    HREADY = 1'b1; HRESP = 1'b0; insert_busy = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    #1;
    nvec++; if (HTRANS !== TR_IDLE) begin nmis++; $display("FAIL reset_htrans got %0d want 0", HTRANS); end
    nvec++; if (HADDR !== 32'h0) begin nmis++; $display("FAIL reset_haddr got %h want 0", HADDR); end
    nvec++; if ({HSIZE, HBURST, HWRITE} !== 7'h0) begin nmis++; $display("FAIL reset_ctl got %h want 0", {HSIZE, HBURST, HWRITE}); end
    nvec++; if (cmd_ready !== 1'b1) begin nmis++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    nvec++; if ({cmd_err, burst_done, burst_err} !== 3'b0) begin nmis++; $display("FAIL reset_pulses got %b want 000", {cmd_err, burst_done, burst_err}); end
    HRESETn = 1'b1;
  endtask

  task automatic test_incr4();
    logic [31:0] ea[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [1:0]  et[4] = '{TR_NONSEQ, TR_SEQ, TR_SEQ, TR_SEQ};
    run_cmd(32'h100, 3'd2, BU_INCR4, 8'd0, 1'b1, 100, 0, -1);
    nvec++; if (ob_addr.size() !== 4) begin nmis++; $display("FAIL incr4_beats got %0d want 4", ob_addr.size()); end
    for (int i = 0; i < 4 && i < ob_addr.size(); i++) begin
      nvec++; if (ob_addr[i] !== ea[i] || ob_trans[i] !== et[i]) begin
        nmis++; $display("FAIL incr4_beat%0d got %h/%0d want %h/%0d", i, ob_addr[i], ob_trans[i], ea[i], et[i]); end
    end
    nvec++; if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
      nmis++; $display("FAIL incr4_done got cnt %0d cyc %0d want cnt 1 cyc %0d", done_cnt, done_cyc, last_cyc + 1); end
  endtask

  task automatic test_wrap4();
    logic [31:0] ea[4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    run_cmd(32'h38, 3'd2, BU_WRAP4, 8'd0, 1'b0, 100, 0, -1);
    nvec++; if (ob_addr.size() !== 4 || ctl_bad !== 0) begin
      nmis++; $display("FAIL wrap4_shape got beats %0d ctlbad %0d want 4 0", ob_addr.size(), ctl_bad); end
    for (int i = 0; i < 4 && i < ob_addr.size(); i++) begin
      nvec++; if (ob_addr[i] !== ea[i]) begin nmis++; $display("FAIL wrap4_beat%0d got %h want %h", i, ob_addr[i], ea[i]); end
    end
  endtask

  task automatic test_incr_split();
    logic [31:0] ea[4] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    logic [1:0]  et[4] = '{TR_NONSEQ, TR_SEQ, TR_NONSEQ, TR_SEQ};
    run_cmd(32'h3F8, 3'd2, BU_INCR, 8'd3, 1'b0, 100, 0, -1);
    nvec++; if (ob_addr.size() !== 4 || done_cnt !== 1 || ctl_bad !== 0) begin
      nmis++; $display("FAIL split_shape got beats %0d done %0d ctlbad %0d want 4 1 0", ob_addr.size(), done_cnt, ctl_bad); end
    for (int i = 0; i < 4 && i < ob_addr.size(); i++) begin
      nvec++; if (ob_addr[i] !== ea[i] || ob_trans[i] !== et[i]) begin
        nmis++; $display("FAIL split_beat%0d got %h/%0d want %h/%0d", i, ob_addr[i], ob_trans[i], ea[i], et[i]); end
    end
  endtask

  task automatic test_stall_busy();
    for (int n = 0; n < 6; n++) begin
      model(32'h1000 + 32'(n * 64), 3'd2, BU_INCR8, 8'd0);
      run_cmd(32'h1000 + 32'(n * 64), 3'd2, BU_INCR8, 8'd0, 1'b1, 45, 55, -1);
      nvec++; if (timed_out !== 0 || hold_bad !== 0 || done_cnt !== 1) begin
        nmis++; $display("FAIL stall%0d got to %0d holdbad %0d done %0d want 0 0 1", n, timed_out, hold_bad, done_cnt); end
      nvec++; if (ob_addr != exp_addr || ob_trans != exp_trans) begin
        nmis++; $display("FAIL stall%0d_beats got %0d beats want %0d", n, ob_addr.size(), exp_addr.size()); end
      for (int k = 0; k < bz_idx.size(); k++) begin
        nvec++; if (bz_idx[k] < 1 || bz_idx[k] >= exp_addr.size() || bz_addr[k] !== exp_addr[bz_idx[k]]) begin
          nmis++; $display("FAIL stall%0d_busy got idx %0d addr %h want next beat address", n, bz_idx[k], bz_addr[k]); end
      end
    end
  endtask

  task automatic test_error();
    run_cmd(32'h200, 3'd2, BU_INCR4, 8'd0, 1'b0, 100, 0, 1);
    nvec++; if (ob_addr.size() !== 2) begin nmis++; $display("FAIL err_beats got %0d want 2", ob_addr.size()); end
    nvec++; if (post_err_tr !== int'(TR_IDLE)) begin nmis++; $display("FAIL err_idle got %0d want 0", post_err_tr); end
    nvec++; if (done_cnt !== 1 || derr_cnt !== 1) begin
      nmis++; $display("FAIL err_done got done %0d err %0d want 1 1", done_cnt, derr_cnt); end
  endtask

  task automatic test_reject();
    run_cmd(32'h102, 3'd2, BU_INCR4, 8'd0, 1'b0, 100, 0, -1);
    nvec++; if (cerr_cnt !== 1 || ob_addr.size() !== 0 || HTRANS !== TR_IDLE) begin
      nmis++; $display("FAIL rej_misalign got err %0d beats %0d htrans %0d want 1 0 0", cerr_cnt, ob_addr.size(), HTRANS); end
    run_cmd(32'h3F0, 3'd2, BU_INCR16, 8'd0, 1'b0, 100, 0, -1);
    nvec++; if (cerr_cnt !== 1 || ob_addr.size() !== 0) begin
      nmis++; $display("FAIL rej_1kb got err %0d beats %0d want 1 0", cerr_cnt, ob_addr.size()); end
    run_cmd(32'h3F0, 3'd2, BU_INCR4, 8'd0, 1'b0, 100, 0, -1);
    nvec++; if (cerr_cnt !== 0 || ob_addr.size() !== 4) begin
      nmis++; $display("FAIL rej_edge got err %0d beats %0d want 0 4", cerr_cnt, ob_addr.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea[6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h500, 32'h0};
    logic [1:0]  et[6] = '{TR_NONSEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_NONSEQ, TR_IDLE};
    logic        er[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        ed[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_size = 3'd2; cmd_burst = BU_INCR4; cmd_len = 8'd0; cmd_write = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0; insert_busy = 1'b0;
    @(negedge HCLK);
    cmd_addr = 32'h500; cmd_burst = BU_SINGLE;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge HCLK);
      if (i == 4) cmd_valid = 1'b0;
      #1;
      nvec++; if (HTRANS !== et[i] || (i < 5 && HADDR !== ea[i])) begin
        nmis++; $display("FAIL b2b_cyc%0d got %0d/%h want %0d/%h", i, HTRANS, HADDR, et[i], ea[i]); end
      nvec++; if (cmd_ready !== er[i] || burst_done !== ed[i]) begin
        nmis++; $display("FAIL b2b_hs%0d got rdy %b done %b want %b %b", i, cmd_ready, burst_done, er[i], ed[i]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_addr = 32'h800; cmd_size = 3'd2; cmd_burst = BU_INCR8; cmd_len = 8'd0;
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK); cmd_valid = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK); #1;
    nvec++; if (HTRANS !== TR_IDLE || HADDR !== 32'h0 || HBURST !== 3'd0 || HSIZE !== 3'd0) begin
      nmis++; $display("FAIL rstmid_bus got %0d %h %0d %0d want 0 0 0 0", HTRANS, HADDR, HBURST, HSIZE); end
    nvec++; if (cmd_ready !== 1'b1 || burst_done !== 1'b0) begin
      nmis++; $display("FAIL rstmid_hs got rdy %b done %b want 1 0", cmd_ready, burst_done); end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a; logic [2:0] sz, bu; logic [7:0] ln; bit wr;
      sz = ($urandom_range(15) == 0) ? 3'd3 : 3'($urandom_range(2));
      bu = 3'($urandom_range(7)); ln = 8'($urandom_range(20)); wr = 1'($urandom_range(1));
      a  = 32'h2000_0000 | 32'($urandom_range(4095));
      if ($urandom_range(9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      model(a, sz, bu, ln);
      run_cmd(a, sz, bu, ln, wr, 70, 30, -1);
      nvec++; if (timed_out !== 0) begin nmis++; $display("FAIL rand%0d_timeout got stuck want done", n); end
      if (!exp_legal) begin
        nvec++; if (cerr_cnt !== 1 || ob_addr.size() !== 0) begin
          nmis++; $display("FAIL rand%0d_rej got err %0d beats %0d want 1 0", n, cerr_cnt, ob_addr.size()); end
      end else begin
        nvec++; if (cerr_cnt !== 0 || done_cnt !== 1 || derr_cnt !== 0 || hold_bad !== 0 || ctl_bad !== 0) begin
          nmis++; $display("FAIL rand%0d_status got err %0d done %0d derr %0d hold %0d ctl %0d want 0 1 0 0 0",
                           n, cerr_cnt, done_cnt, derr_cnt, hold_bad, ctl_bad); end
        nvec++; if (ob_addr.size() !== exp_addr.size()) begin
          nmis++; $display("FAIL rand%0d_count got %0d want %0d", n, ob_addr.size(), exp_addr.size()); end
        for (int i = 0; i < ob_addr.size() && i < exp_addr.size(); i++) begin
          nvec++; if (ob_addr[i] !== exp_addr[i] || ob_trans[i] !== exp_trans[i]) begin
            nmis++; $display("FAIL rand%0d_beat%0d got %h/%0d want %h/%0d", n, i, ob_addr[i], ob_trans[i], exp_addr[i], exp_trans[i]); end
        end
        for (int k = 0; k < bz_idx.size(); k++) begin
          nvec++; if (bz_idx[k] < 1 || bz_idx[k] >= exp_addr.size() || bz_addr[k] !== exp_addr[bz_idx[k]]) begin
            nmis++; $display("FAIL rand%0d_busy got idx %0d addr %h want next beat address", n, bz_idx[k], bz_addr[k]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr4();
    test_wrap4();
    test_incr_split();
    test_stall_busy();
    test_error();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
endmodule
